// File: rtl/mux2_arb_pkg.sv
// Shared types and constants for the round-robin select controller in front of mux2.
package mux2_arb_pkg;

  localparam int         CNT_W   = 4;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_GNT0 = 2'd1;
  localparam logic [1:0] ST_GNT1 = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    GNT0 = ST_GNT0,
    GNT1 = ST_GNT1
  } state_t;

endpackage

// File: rtl/mux2.sv
// Plain 2:1 data mux: j=0 passes i0, j=1 passes i1.
module mux2 #(
  parameter int W = 8
) (
  input  logic [W-1:0] i0,
  input  logic [W-1:0] i1,
  input  logic         j,
  output logic [W-1:0] o
);

  assign o = j ? i1 : i0;

endmodule

// File: rtl/mux2_rr_arbiter_burst_cnt.sv
// Consecutive-transfer counter: clear wins over increment, saturates at BURST_MAX-1.
module burst_cnt
  import mux2_arb_pkg::*;
#(
  parameter int BURST_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_tc
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(BURST_MAX - 1);

  logic [CNT_W-1:0] r_cnt;

  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != TC_VAL)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tc = (r_cnt == TC_VAL);

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter driving the mux2 select, with a per-grant burst limit and
// a valid/ready handshake toward the consumer of the mux output.
module mux2_rr_arbiter
  import mux2_arb_pkg::*;
#(
  parameter int BURST_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  input  logic out_ready,
  output logic grant0,
  output logic grant1,
  output logic sel,
  output logic out_valid
);

  state_t r_state;
  state_t w_next;
  logic   r_last;
  logic   r_sel;
  logic   w_xfer;
  logic   w_tc;
  logic   w_clr;

  assign grant0    = (r_state == GNT0);
  assign grant1    = (r_state == GNT1);
  assign sel       = r_sel;
  assign out_valid = (grant0 & req0) | (grant1 & req1);
  assign w_xfer    = out_valid & out_ready;
  assign w_clr     = (w_next != r_state);

  // NOTE: w_next is defaulted before the case so no path leaves it unassigned (no latch).
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (req0 && req1)  w_next = r_last ? GNT0 : GNT1;
        else if (req0)     w_next = GNT0;
        else if (req1)     w_next = GNT1;
      end
      GNT0: begin
        if (!req0)                     w_next = req1 ? GNT1 : IDLE;
        else if (w_xfer && w_tc && req1) w_next = GNT1;
      end
      GNT1: begin
        if (!req1)                     w_next = req0 ? GNT0 : IDLE;
        else if (w_xfer && w_tc && req0) w_next = GNT0;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_sel   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_xfer) r_last <= (r_state == GNT1);
      // sel follows the next grant and holds through IDLE so the mux output stays stable
      if (w_next == GNT0)      r_sel <= 1'b0;
      else if (w_next == GNT1) r_sel <= 1'b1;
    end
  end

  burst_cnt #(
    .BURST_MAX (BURST_MAX)
  ) u_burst_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_clr),
    .i_inc (w_xfer),
    .o_tc  (w_tc)
  );

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Integration bench for mux2_rr_arbiter + mux2: random traffic against a behavioural
// arbitration model; expected per-cycle outputs flow through a scoreboard queue.
module tb_mux2_rr_arbiter;

  localparam int BM = 4;
  localparam int W  = 8;
  localparam int N_CYCLES = 2000;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0, req1, out_ready;
  logic         grant0, grant1, sel, out_valid;
  logic [W-1:0] i0, i1, o;

  always #5 clk = ~clk;

  mux2_rr_arbiter #(.BURST_MAX(BM)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .req1      (req1),
    .out_ready (out_ready),
    .grant0    (grant0),
    .grant1    (grant1),
    .sel       (sel),
    .out_valid (out_valid)
  );

  mux2 #(.W(W)) u_mux (
    .i0 (i0),
    .i1 (i1),
    .j  (sel),
    .o  (o)
  );

  typedef struct packed {
    logic         g0;
    logic         g1;
    logic         sel;
    logic         valid;
    logic [W-1:0] o;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: owner is -1 (nobody), 0 or 1; served counts back-to-back transfers.
  int   own;
  int   served;
  int   last_src;
  logic m_sel;
  logic m_xfer;
  int   pending[2];
  bit   force_both;
  int   ready_pct;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    own      = -1;
    served   = 0;
    last_src = 1;
    m_sel    = 1'b0;
    m_xfer   = 1'b0;
  endtask

  // Applied at each rising edge using the inputs that were present for that edge.
  task automatic model_edge();
    int  prev;
    int  other;
    bit  r[2];
    r[0] = req0;
    r[1] = req1;
    prev = own;
    if (m_xfer) begin
      last_src = own;
      pending[own]--;
    end
    if (own < 0) begin
      if (r[0] && r[1]) own = (last_src == 1) ? 0 : 1;
      else if (r[0])    own = 0;
      else if (r[1])    own = 1;
    end else begin
      other = 1 - own;
      if (!r[own])                                  own = r[other] ? other : -1;
      else if (m_xfer && served == BM - 1 && r[other]) own = other;
    end
    if (own != prev)  served = 0;
    else if (m_xfer)  served = (served + 1 > BM - 1) ? BM - 1 : served + 1;
    if (own >= 0) m_sel = (own == 1);
  endtask

  // Drive the next cycle's inputs and queue the outputs the model expects for it.
  task automatic drive();
    exp_t e;
    for (int s = 0; s < 2; s++) begin
      if (force_both) pending[s] = 1000;
      else if (pending[s] > 8) pending[s] = $urandom_range(8, 1);
      else if (pending[s] == 0 && $urandom_range(99, 0) < 30) pending[s] = $urandom_range(6, 1);
      else if (pending[s] > 0 && $urandom_range(99, 0) < 4) pending[s] = 0;
    end
    req0      = (pending[0] > 0);
    req1      = (pending[1] > 0);
    out_ready = ($urandom_range(99, 0) < ready_pct);
    i0        = W'($urandom);
    i1        = W'($urandom);
    e.g0      = (own == 0);
    e.g1      = (own == 1);
    e.sel     = m_sel;
    e.valid   = (own == 0 && req0) || (own == 1 && req1);
    e.o       = m_sel ? i1 : i0;
    m_xfer    = e.valid && out_ready;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("cycle {grant0,grant1,sel,out_valid,o}",
            32'({grant0, grant1, sel, out_valid, o}), 32'(e));
    end
  end

  initial begin
    rst        = 1'b1;
    req0       = 1'b0;
    req1       = 1'b0;
    out_ready  = 1'b0;
    i0         = '0;
    i1         = '0;
    pending[0] = 0;
    pending[1] = 0;
    force_both = 1'b1;
    ready_pct  = 100;
    model_reset();
    #2;
    check("reset grant0", 32'(grant0), 32'd0);
    check("reset grant1", 32'(grant1), 32'd0);
    check("reset sel", 32'(sel), 32'd0);
    check("reset out_valid", 32'(out_valid), 32'd0);
    #1 rst = 1'b0;

    for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
      @(posedge clk);
      model_edge();
      #1;
      if (cyc == 80)  ready_pct = 70;
      if (cyc == 160) begin
        force_both = 1'b0;
        ready_pct  = 80;
      end
      if (cyc == 1000) ready_pct = 100;
      drive();
      if (cyc == 58) begin
        // Asynchronous reset pulse between edges, in the middle of a saturated burst.
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async rst grant0", 32'(grant0), 32'd0);
        check("async rst grant1", 32'(grant1), 32'd0);
        check("async rst sel", 32'(sel), 32'd0);
        check("async rst out_valid", 32'(out_valid), 32'd0);
        #1 rst = 1'b0;
        model_reset();
      end
    end

    @(negedge clk);
    #1;
    check("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
